// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state type and the single-digit add-3 correction for bin2bcd_seq.
package bin2bcd_pkg;

    localparam int BCD_DIGITS     = 4;
    localparam int SCRATCH_DIGITS = 5;
    localparam logic [13:0] MAX_DEC = 14'd9999;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Pre-shift correction: digits 5..9 become 8..12 so the shift carries into the next digit.
    function automatic logic [3:0] digit_adj(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3-if->=5 correction for one BCD digit of the double-dabble scratch.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = digit_adj(i_digit);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one shift per clock).
// Define BIN2BCD_SAT_EN to clamp values above 9999 to 9999 instead of dropping the 5th digit.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IN_W-1:0]         bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int SCR_W = 4 * SCRATCH_DIGITS;
    localparam int CNT_W = 5;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IN_W-1:0]         r_bin_sr;
    logic [SCR_W-1:0]        r_scratch;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf_next;
    logic                    r_done;
    logic                    r_ovf;
    logic [4*BCD_DIGITS-1:0] r_bcd;

    logic [SCR_W-1:0]        w_adj;
    logic [SCR_W-1:0]        w_shifted;
    logic [16:0]             w_bin_ext;
    logic                    w_ovf_in;
    logic [IN_W-1:0]         w_load;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_unused_msb;

    generate
        for (genvar gi = 0; gi < SCRATCH_DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_scratch[4*gi +: 4]),
                .o_digit (w_adj[4*gi +: 4])
            );
        end
    endgenerate

    // Top scratch bit never holds data for inputs up to 65535, so it is shifted out unused.
    assign w_unused_msb = w_adj[SCR_W-1];
    assign w_shifted    = {w_adj[SCR_W-2:0], r_bin_sr[IN_W-1]};

    assign w_bin_ext = 17'(bin);
    assign w_ovf_in  = (w_bin_ext > 17'(MAX_DEC));
`ifdef BIN2BCD_SAT_EN
    assign w_load = w_ovf_in ? IN_W'(MAX_DEC) : bin;
`else
    assign w_load = bin;
`endif

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin_sr   <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_bin_sr   <= w_load;
                r_scratch  <= '0;
                r_cnt      <= CNT_W'(IN_W);
                r_ovf_next <= w_ovf_in;
            end else if (r_state == SHIFT) begin
                r_scratch <= w_shifted;
                r_bin_sr  <= {r_bin_sr[IN_W-2:0], 1'b0};
                r_cnt     <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    // Result and flag land together so the display never sees a partial value.
                    r_bcd  <= w_shifted[4*BCD_DIGITS-1:0];
                    r_ovf  <= r_ovf_next;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard testbench for bin2bcd_seq: expected {ovf,bcd} queued at start, checked at done.
module tb_bin2bcd_seq;

    localparam int IN_W = 14;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [IN_W-1:0] bin;
    logic            busy;
    logic            done;
    logic [15:0]     bcd;
    logic            ovf;

    int total = 0;
    int bad   = 0;
    logic [16:0] sb[$];

    bin2bcd_seq #(.IN_W(IN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input int v);
        int x;
        logic o;
        o = (v > 9999);
        x = v;
`ifdef BIN2BCD_SAT_EN
        if (o) x = 9999;
`endif
        x = x % 10000;
        return {o, 4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int v);
        bin   = IN_W'(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(model(v));
        $display("start bin=%0d", v);
    endtask

    // Returns cycles after acceptance until done is seen, or -1 on timeout.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                cycles = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bin = '0;
        repeat (3) tick();
        total++;
        if ({busy, done, ovf, bcd} !== 19'd0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b ovf=%b bcd=%h want all zero", busy, done, ovf, bcd);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [16:0] exp;
        int busy_cnt = 0;
        int done_at  = -1;
        do_start(1234);
        for (int i = 1; i <= 20; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1 && done_at < 0) done_at = i - 1;
            if (done_at >= 0) break;
            tick();
        end
        total++;
        if (busy_cnt !== 14) begin
            bad++;
            $display("FAIL basic_busy_len got %0d want 14", busy_cnt);
        end
        total++;
        if (done_at !== 14) begin
            bad++;
            $display("FAIL basic_latency got %0d want 14", done_at);
        end
        exp = sb.pop_front();
        total++;
        if ({ovf, bcd} !== exp) begin
            bad++;
            $display("FAIL basic_result got ovf=%b bcd=%h want ovf=%b bcd=%h", ovf, bcd, exp[16], exp[15:0]);
        end
        $display("done bin=1234 bcd=%h ovf=%b", bcd, ovf);
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse got done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        int cyc;
        do_start(0);
        wait_done(cyc);
        exp = sb.pop_front();
        total++;
        if (cyc !== 14 || {ovf, bcd} !== exp) begin
            bad++;
            $display("FAIL b2b_first got cyc=%0d ovf=%b bcd=%h want 14 ovf=%b bcd=%h", cyc, ovf, bcd, exp[16], exp[15:0]);
        end
        $display("done bin=0 bcd=%h ovf=%b", bcd, ovf);
        do_start(9999);
        wait_done(cyc);
        exp = sb.pop_front();
        total++;
        if (cyc !== 14) begin
            bad++;
            $display("FAIL b2b_latency got %0d want 14", cyc);
        end
        total++;
        if ({ovf, bcd} !== exp || exp[15:0] !== 16'h9999) begin
            bad++;
            $display("FAIL b2b_second got ovf=%b bcd=%h want ovf=0 bcd=9999", ovf, bcd);
        end
        $display("done bin=9999 bcd=%h ovf=%b", bcd, ovf);
    endtask

    task automatic test_overflow();
        logic [16:0] exp;
        int cyc;
        do_start(12345);
        wait_done(cyc);
        exp = sb.pop_front();
        total++;
        if (cyc !== 14 || {ovf, bcd} !== exp || ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow_12345 got cyc=%0d ovf=%b bcd=%h want 14 ovf=%b bcd=%h", cyc, ovf, bcd, exp[16], exp[15:0]);
        end
        $display("done bin=12345 bcd=%h ovf=%b", bcd, ovf);
        do_start(10000);
        wait_done(cyc);
        exp = sb.pop_front();
        total++;
        if ({ovf, bcd} !== exp) begin
            bad++;
            $display("FAIL overflow_10000 got ovf=%b bcd=%h want ovf=%b bcd=%h", ovf, bcd, exp[16], exp[15:0]);
        end
        $display("done bin=10000 bcd=%h ovf=%b", bcd, ovf);
    endtask

    task automatic test_start_while_busy();
        logic [16:0] exp;
        int cyc;
        int extra = 0;
        do_start(4321);
        repeat (4) tick();
        bin   = IN_W'(5678);
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = '0;
        wait_done(cyc);
        total++;
        if (cyc !== 9) begin
            bad++;
            $display("FAIL busy_ignore_latency got %0d want 9", cyc);
        end
        exp = sb.pop_front();
        total++;
        if ({ovf, bcd} !== exp) begin
            bad++;
            $display("FAIL busy_ignore_result got ovf=%b bcd=%h want ovf=%b bcd=%h", ovf, bcd, exp[16], exp[15:0]);
        end
        $display("done bin=4321 bcd=%h ovf=%b", bcd, ovf);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL busy_ignore_single got %0d extra busy/done cycles want 0", extra);
        end
    endtask

    task automatic test_abort();
        logic [16:0] exp;
        int cyc;
        int seen = 0;
        bin   = IN_W'(8765);
        start = 1'b1;
        tick();
        start = 1'b0;
        $display("start bin=8765 (to be aborted)");
        repeat (6) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        total++;
        if ({busy, done, ovf, bcd} !== 19'd0) begin
            bad++;
            $display("FAIL abort_state got busy=%b done=%b ovf=%b bcd=%h want all zero", busy, done, ovf, bcd);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_no_done got %0d busy/done cycles want 0", seen);
        end
        do_start(42);
        wait_done(cyc);
        exp = sb.pop_front();
        total++;
        if (cyc !== 14 || {ovf, bcd} !== exp) begin
            bad++;
            $display("FAIL abort_restart got cyc=%0d ovf=%b bcd=%h want 14 ovf=%b bcd=%h", cyc, ovf, bcd, exp[16], exp[15:0]);
        end
        $display("done bin=42 bcd=%h ovf=%b", bcd, ovf);
    endtask

    task automatic test_sweep();
        logic [16:0] exp;
        int cyc;
        int v;
        int digit_bad;
        for (int n = 0; n < 40; n++) begin
            v = (n == 0) ? 16383 : int'($urandom_range(0, 16383));
            do_start(v);
            wait_done(cyc);
            exp = sb.pop_front();
            digit_bad = 0;
            for (int d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] > 4'd9) digit_bad++;
            end
            total++;
            if (cyc !== 14 || digit_bad !== 0 || {ovf, bcd} !== exp) begin
                bad++;
                $display("FAIL sweep bin=%0d got cyc=%0d ovf=%b bcd=%h want 14 ovf=%b bcd=%h", v, cyc, ovf, bcd, exp[16], exp[15:0]);
            end
            $display("done bin=%0d bcd=%h ovf=%b", v, bcd, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_start_while_busy();
        test_abort();
        test_sweep();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_empty got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
